// File: rtl/hashrate_monitor.sv
// rtl/hashrate_monitor.sv - per-second hash rate, saturating lifetime total, peak rate and report handshake
module hashrate_monitor #(
  parameter int CNT_W   = 32,
  parameter int TOTAL_W = 48
) (
  input  logic               clk,
  input  logic               rst_i,
  input  logic               enable_i,
  input  logic               clear_i,
  input  logic               second_tick,
  input  logic               hash_done_i,
  output logic [CNT_W-1:0]   rate_o,
  output logic               rate_valid_o,
  input  logic               rate_ready_i,
  output logic [TOTAL_W-1:0] total_o,
  output logic [CNT_W-1:0]   peak_o,
  output logic               missed_o
);

  typedef enum logic {SYNC, MEASURE} state_t;

  localparam logic [CNT_W-1:0]   CNT_ONE   = CNT_W'(1);
  localparam logic [TOTAL_W-1:0] TOTAL_ONE = TOTAL_W'(1);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   win_q, win_d;
  logic [CNT_W-1:0]   rate_q, rate_d;
  logic               valid_q, valid_d;
  logic [TOTAL_W-1:0] total_q, total_d;
  logic [CNT_W-1:0]   peak_q, peak_d;
  logic               missed_q, missed_d;
  logic [CNT_W-1:0]   win_inc;

  always_comb begin
    win_inc = win_q;
    if (hash_done_i && !(&win_q)) begin
      win_inc = win_q + CNT_ONE;
    end

    state_d  = state_q;
    win_d    = win_q;
    rate_d   = rate_q;
    valid_d  = valid_q;
    total_d  = total_q;
    peak_d   = peak_q;
    missed_d = missed_q;

    if (clear_i) begin
      state_d  = SYNC;
      win_d    = '0;
      valid_d  = 1'b0;
      total_d  = '0;
      peak_d   = '0;
      missed_d = 1'b0;
    end else begin
      if (valid_q && rate_ready_i) begin
        valid_d = 1'b0;
      end
      if (!enable_i) begin
        // Disabled: the open window is abandoned and hashes are ignored.
        state_d = SYNC;
        win_d   = '0;
      end else begin
        if (hash_done_i && !(&total_q)) begin
          total_d = total_q + TOTAL_ONE;
        end
        case (state_q)
          SYNC: begin
            win_d = '0;
            if (second_tick) begin
              state_d = MEASURE;
            end
          end
          MEASURE: begin
            if (second_tick) begin
              // A hash in the closing cycle belongs to the window being reported.
              rate_d  = win_inc;
              valid_d = 1'b1;
              win_d   = '0;
              if (win_inc > peak_q) begin
                peak_d = win_inc;
              end
              if (valid_q && !rate_ready_i) begin
                missed_d = 1'b1;
              end
            end else begin
              win_d = win_inc;
            end
          end
          default: state_d = SYNC;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_i) begin
    if (!rst_i) begin
      state_q  <= SYNC;
      win_q    <= '0;
      rate_q   <= '0;
      valid_q  <= 1'b0;
      total_q  <= '0;
      peak_q   <= '0;
      missed_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      win_q    <= win_d;
      rate_q   <= rate_d;
      valid_q  <= valid_d;
      total_q  <= total_d;
      peak_q   <= peak_d;
      missed_q <= missed_d;
    end
  end

  assign rate_o       = rate_q;
  assign rate_valid_o = valid_q;
  assign total_o      = total_q;
  assign peak_o       = peak_q;
  assign missed_o     = missed_q;

endmodule

// File: tb/tb_hashrate_monitor.sv
// tb/tb_hashrate_monitor.sv - directed and randomized checks of hashrate_monitor against a window/report model
module tb_hashrate_monitor;

  localparam int CNT_W   = 4;
  localparam int TOTAL_W = 8;
  localparam int CMAX    = (1 << CNT_W) - 1;
  localparam int TMAX    = (1 << TOTAL_W) - 1;

  logic               clk = 1'b0;
  logic               rst_i = 1'b0;
  logic               enable_i = 1'b0;
  logic               clear_i = 1'b0;
  logic               second_tick = 1'b0;
  logic               hash_done_i = 1'b0;
  logic               rate_ready_i = 1'b0;
  logic [CNT_W-1:0]   rate_o;
  logic               rate_valid_o;
  logic [TOTAL_W-1:0] total_o;
  logic [CNT_W-1:0]   peak_o;
  logic               missed_o;

  int checks = 0;
  int errors = 0;

  // Reference: "measuring" means a clean window start has been seen.
  bit m_measuring;
  int m_win, m_rate, m_total, m_peak;
  bit m_valid, m_missed;

  hashrate_monitor #(.CNT_W(CNT_W), .TOTAL_W(TOTAL_W)) dut (
    .clk(clk), .rst_i(rst_i), .enable_i(enable_i), .clear_i(clear_i),
    .second_tick(second_tick), .hash_done_i(hash_done_i),
    .rate_o(rate_o), .rate_valid_o(rate_valid_o), .rate_ready_i(rate_ready_i),
    .total_o(total_o), .peak_o(peak_o), .missed_o(missed_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_measuring = 0; m_win = 0; m_rate = 0; m_total = 0;
    m_peak = 0; m_valid = 0; m_missed = 0;
  endtask

  task automatic model_step(input bit en, input bit clr, input bit tick, input bit hash, input bit rdy);
    int w;
    if (clr) begin
      m_total = 0; m_peak = 0; m_missed = 0; m_valid = 0;
      m_measuring = 0; m_win = 0;
    end else begin
      bit accepted;
      accepted = m_valid && rdy;
      if (!en) begin
        m_measuring = 0;
        m_win = 0;
        if (accepted) m_valid = 0;
      end else begin
        if (hash) m_total = (m_total + 1 > TMAX) ? TMAX : m_total + 1;
        if (!m_measuring) begin
          if (tick) m_measuring = 1;
          if (accepted) m_valid = 0;
        end else begin
          w = (m_win + hash > CMAX) ? CMAX : m_win + hash;
          if (tick) begin
            if (m_valid && !rdy) m_missed = 1;
            m_rate = w;
            m_valid = 1;
            if (w > m_peak) m_peak = w;
            m_win = 0;
          end else begin
            m_win = w;
            if (accepted) m_valid = 0;
          end
        end
      end
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".rate"},   64'(rate_o),       64'(m_rate));
    chk({tag, ".valid"},  64'(rate_valid_o), 64'(m_valid));
    chk({tag, ".total"},  64'(total_o),      64'(m_total));
    chk({tag, ".peak"},   64'(peak_o),       64'(m_peak));
    chk({tag, ".missed"}, 64'(missed_o),     64'(m_missed));
  endtask

  // Called at a negedge; applies inputs for one clock and checks at the following negedge.
  task automatic cyc(input bit en, input bit clr, input bit tick, input bit hash, input bit rdy,
                     input string tag);
    enable_i = en; clear_i = clr; second_tick = tick; hash_done_i = hash; rate_ready_i = rdy;
    @(posedge clk);
    model_step(en, clr, tick, hash, rdy);
    @(negedge clk);
    check_all(tag);
  endtask

  task automatic hashes(input int n, input string tag);
    for (int i = 0; i < n; i++) cyc(1, 0, 0, 1, 0, tag);
  endtask

  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    check_all("reset");
    rst_i = 1'b1;

    // 1: basic window of 7
    cyc(1, 0, 1, 0, 0, "t1_open");
    hashes(7, "t1_hash");
    cyc(1, 0, 1, 0, 0, "t1_close");
    chk("t1_rate7", 64'(rate_o), 64'd7);
    chk("t1_valid", 64'(rate_valid_o), 64'd1);
    chk("t1_peak7", 64'(peak_o), 64'd7);
    chk("t1_total7", 64'(total_o), 64'd7);
    cyc(1, 0, 0, 0, 1, "t1_accept");
    chk("t1_valid_drop", 64'(rate_valid_o), 64'd0);

    // 2: pre-window hashes count only into total
    cyc(1, 1, 0, 0, 0, "t2_clear");
    hashes(3, "t2_pre");
    cyc(1, 0, 1, 0, 0, "t2_open");
    hashes(5, "t2_hash");
    cyc(1, 0, 1, 0, 0, "t2_close");
    chk("t2_rate5", 64'(rate_o), 64'd5);
    chk("t2_total8", 64'(total_o), 64'd8);

    // 3: hash coincident with closing tick
    cyc(1, 0, 0, 0, 1, "t3_accept");
    hashes(4, "t3_hash");
    cyc(1, 0, 1, 1, 0, "t3_close");
    chk("t3_rate5", 64'(rate_o), 64'd5);
    cyc(1, 0, 1, 0, 1, "t3_empty");
    chk("t3_rate0", 64'(rate_o), 64'd0);
    chk("t3_nomiss", 64'(missed_o), 64'd0);

    // 4: overwrite then clear
    cyc(1, 1, 0, 0, 0, "t4_clear");
    cyc(1, 0, 1, 0, 0, "t4_open");
    hashes(3, "t4_h3");
    cyc(1, 0, 1, 0, 0, "t4_r3");
    hashes(9, "t4_h9");
    cyc(1, 0, 1, 0, 0, "t4_r9");
    chk("t4_rate9", 64'(rate_o), 64'd9);
    chk("t4_missed", 64'(missed_o), 64'd1);
    chk("t4_peak9", 64'(peak_o), 64'd9);
    cyc(1, 1, 1, 1, 0, "t4_clear_tick");
    chk("t4_total0", 64'(total_o), 64'd0);
    chk("t4_valid0", 64'(rate_valid_o), 64'd0);
    chk("t4_missed0", 64'(missed_o), 64'd0);

    // 5: enable dropped mid-window
    cyc(1, 0, 1, 0, 0, "t5_open");
    hashes(6, "t5_h6");
    cyc(0, 0, 0, 1, 0, "t5_disable");
    cyc(1, 0, 1, 0, 0, "t5_reopen");
    chk("t5_noreport", 64'(rate_valid_o), 64'd0);
    hashes(2, "t5_h2");
    cyc(1, 0, 1, 0, 0, "t5_close");
    chk("t5_rate2", 64'(rate_o), 64'd2);

    // 6: window saturation, then async reset mid-window
    cyc(1, 0, 1, 0, 1, "t6_open");
    hashes(20, "t6_h20");
    cyc(1, 0, 1, 0, 0, "t6_close");
    chk("t6_rate_sat", 64'(rate_o), 64'(CMAX));
    hashes(3, "t6_h3");
    #2 rst_i = 1'b0;
    #1;
    model_reset();
    check_all("t6_async_rst");
    @(negedge clk);
    rst_i = 1'b1;
    cyc(1, 0, 1, 0, 0, "t6_tick_after_rst");
    chk("t6_noreport", 64'(rate_valid_o), 64'd0);

    // Randomized traffic; totals are expected to saturate along the way.
    for (int i = 0; i < 3000; i++) begin
      cyc(($urandom_range(0, 19) != 0), ($urandom_range(0, 199) == 0),
          ($urandom_range(0, 11) == 0), ($urandom_range(0, 2) != 0),
          ($urandom_range(0, 3) == 0), "rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
